// File: rtl/fire_ofm_serializer.sv
// fire_ofm_serializer: parallel-to-serial bridge from a fire layer's MAC bank
// to the next layer's 16-bit ifm stream. One DSP_NO-wide vector (one pixel,
// all output channels) is captured per accepted ofm_valid strobe. It is then
// replayed one word per cycle, channel 0 first, under a valid/ready handshake.
// Fully drained vectors are counted, and layer_done is flagged after
// NUM_VECTORS of them.
//
// Build option: FIRE_SER_DBLBUF_EN
//   defined   -> two capture banks (ping-pong). The producer may load vector
//                k+1 while vector k drains.
//   undefined -> one capture bank. The producer must wait until the vector
//                has fully drained.
module fire_ofm_serializer #(
  parameter int DSP_NO      = 64,
  parameter int WIDTH       = 16,
  parameter int NUM_VECTORS = 256
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             ser_en,
  input  logic [WIDTH-1:0]                 ofm_in [0:DSP_NO-1],
  input  logic                             ofm_valid,
  output logic                             ofm_ready,
  output logic [WIDTH-1:0]                 ifm_out,
  output logic                             ifm_valid,
  input  logic                             ifm_ready,
  output logic [$clog2(DSP_NO)-1:0]        ch_idx,
  output logic [$clog2(NUM_VECTORS+1)-1:0] px_idx,
  output logic                             overflow,
  output logic                             layer_done
);

`ifdef FIRE_SER_DBLBUF_EN
  localparam int NBANK = 2;
`else
  localparam int NBANK = 1;
`endif

  localparam int CH_W  = $clog2(DSP_NO);
  localparam int PX_W  = $clog2(NUM_VECTORS + 1);
  localparam int PTR_W = (NBANK > 1) ? $clog2(NBANK) : 1;

  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(DSP_NO - 1);
  localparam logic [PX_W-1:0]  PX_LAST  = PX_W'(NUM_VECTORS - 1);
  localparam logic [PX_W-1:0]  PX_MAX   = PX_W'(NUM_VECTORS);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NBANK - 1);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t             state;
  logic               en_q;
  logic [NBANK-1:0]   full;
  logic [NBANK-1:0]   full_next;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   rd_ptr_next;
  logic [WIDTH-1:0]   bank [0:NBANK-1][0:DSP_NO-1];
  logic               capture;
  logic               last_hs;

  // Ready depends only on registered state: a bank freed on this edge is not
  // reported as ready until the following cycle.
  assign ofm_ready   = en_q && !layer_done && !(&full);
  assign capture     = ser_en && ofm_valid && ofm_ready;
  assign last_hs     = (state == STREAM) && ifm_valid && ifm_ready && (ch_idx == CH_LAST);
  assign rd_ptr_next = (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
  assign ifm_out     = ifm_valid ? bank[rd_ptr][ch_idx] : '0;

  // Bank occupancy after this edge: the drained bank is freed and a capture fills the write bank.
  always_comb begin
    full_next = full;
    if (last_hs) full_next[rd_ptr] = 1'b0;
    if (capture) full_next[wr_ptr] = 1'b1;
  end

  // Vector storage is written whole on a capture; it needs no reset because full[] guards it.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < DSP_NO; i++) bank[wr_ptr][i] <= ofm_in[i];
    end
  end

  // Drain FSM plus bank bookkeeping, pixel counter and the sticky flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      en_q       <= 1'b0;
      full       <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ch_idx     <= '0;
      px_idx     <= '0;
      ifm_valid  <= 1'b0;
      overflow   <= 1'b0;
      layer_done <= 1'b0;
    end else if (!ser_en) begin
      state      <= IDLE;
      en_q       <= 1'b0;
      full       <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ch_idx     <= '0;
      px_idx     <= '0;
      ifm_valid  <= 1'b0;
      overflow   <= 1'b0;
      layer_done <= 1'b0;
    end else begin
      en_q <= 1'b1;
      full <= full_next;
      if (ofm_valid && !ofm_ready) overflow <= 1'b1;
      if (capture) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      case (state)
        IDLE: begin
          if (full_next[rd_ptr]) begin
            state     <= STREAM;
            ch_idx    <= '0;
            ifm_valid <= 1'b1;
          end
        end
        STREAM: begin
          if (ifm_ready) begin
            if (ch_idx == CH_LAST) begin
              ch_idx <= '0;
              rd_ptr <= rd_ptr_next;
              if (px_idx != PX_MAX) px_idx <= px_idx + 1'b1;
              if (px_idx == PX_LAST) begin
                state      <= DONE;
                ifm_valid  <= 1'b0;
                layer_done <= 1'b1;
              end else if (!full_next[rd_ptr_next]) begin
                state     <= IDLE;
                ifm_valid <= 1'b0;
              end
            end else begin
              ch_idx <= ch_idx + 1'b1;
            end
          end
        end
        DONE: begin
          ifm_valid  <= 1'b0;
          layer_done <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          ifm_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
